joy_db15_tx: RTL and testbench
==============================

Name: joy_db15_tx

Overview:
- Device-side emitter for the serial DB15 joystick link, the opposite end of joy_db15.
- Mimics the adapter's chained parallel-in/serial-out shift registers: loads two 12-bit pad words while JOY_LOAD is low, then shifts one bit per JOY_CLK rising edge onto JOY_DATA.
- Used in bench models and in a core that acts as the adapter. The line is active-low: button pressed drives the line low.

Parameters:
- FRAME_BITS, 24, total bits per frame (two players x 12).
- SYNC_STAGES, 2, synchronizer depth for JOY_CLK and JOY_LOAD.
- TIMEOUT, 4096, idle clk_sys cycles in SHIFT before the frame is abandoned.

Ports:
- clk_sys  in  1  system clock, only clock domain.
- RESET_N  in  1  asynchronous active-low reset.
- JOY_CLK  in  1  host shift clock, asynchronous to clk_sys.
- JOY_LOAD  in  1  host load strobe, active-low, asynchronous.
- joystick1  in  12  player-1 buttons, 1 = pressed; [0]R [1]L [2]D [3]U [4..11] buttons.
- joystick2  in  12  player-2 buttons, same mapping.
- JOY_DATA  out  1  serial data, registered, active-low.
- bit_cnt  out  5  bits shifted since the last load, saturating at FRAME_BITS.
- frame_done  out  1  one-cycle pulse when bit_cnt reaches FRAME_BITS.
- timeout  out  1  one-cycle pulse when a frame is abandoned.
- active  out  1  high in SHIFT state.

Behaviour:
- Reset (async, RESET_N=0):
  - state=IDLE, sr=0, bit_cnt=0, JOY_DATA=1.
  - frame_done=0, timeout=0, active=0.
  - Synchronizer flops are set to 1 (lines idle high).
- Synchronization:
  - JOY_CLK and JOY_LOAD each pass through SYNC_STAGES flops.
  - clk_rise = synced JOY_CLK 0->1, detected against a further registered copy.
  - Input-to-effect latency is SYNC_STAGES+1 cycles.
- Frame word: F[23:0] = {joystick2, joystick1}, sampled on load.
- JOY_DATA is registered each cycle: JOY_DATA <= ~sr[0].
- States:
  - IDLE: sr holds its value, JOY_DATA shows ~sr[0]. Synced LOAD=0 -> LOAD.
  - LOAD: while synced LOAD=0, sr <= F every cycle (transparent load), bit_cnt <= 0, clk_rise ignored. Synced LOAD=1 -> SHIFT, wdog <= 0.
  - SHIFT: on clk_rise, sr <= {1'b0, sr[23:1]} (fill reads as released) and bit_cnt <= bit_cnt+1, saturating at FRAME_BITS.
- SHIFT exits:
  - When the increment makes bit_cnt = FRAME_BITS: frame_done pulses in the same cycle bit_cnt updates. State stays SHIFT; further clk_rise shifts zeros, bit_cnt holds at FRAME_BITS, no further frame_done.
  - Synced LOAD=0 -> LOAD. Load wins over a simultaneous clk_rise.
  - wdog counts clk_sys cycles without clk_rise and clears on clk_rise. When wdog reaches TIMEOUT-1: timeout pulses, state -> IDLE, sr <= 0, bit_cnt held.
- active = (state==SHIFT).
- Outputs stay registered; there are no combinational paths from inputs to outputs.
- Pad inputs changing during SHIFT have no effect until the next load.
- A LOAD pulse shorter than SYNC_STAGES+1 cycles may be missed. The host is required to hold LOAD low for at least 4 clk_sys cycles and each JOY_CLK phase for at least 4 cycles.
- Reset mid-frame: immediate return to reset values. JOY_LOAD already low at reset release enters LOAD after sync latency.

Decomposition:
- Package joy_db15_pkg holds:
  - state enum {IDLE, LOAD, SHIFT};
  - FRAME_BITS default;
  - bit-index constants for U/D/L/R/B1..B8.
- One sub-module, db15_sync_edge: parameterised N-stage synchronizer plus rise/fall detect with reset value 1. Instantiated twice.
- Shift register, counters and FSM stay in the top.

Test Plan:
- Reset with JOY_LOAD=1, JOY_CLK=0 -> JOY_DATA=1, bit_cnt=0, active=0, no pulses.
- joystick1=12'h009, joystick2=12'h000, then LOAD low 8 cycles, high, then 24 JOY_CLK pulses -> JOY_DATA sequence (pre-shift, after each edge) 0,1,1,0,1...; frame_done pulses once at the 24th edge; bit_cnt=24.
- joystick2=12'hFFF, joystick1=0, then a full frame -> first 12 bits 1, next 12 bits 0, and after 26 clocks JOY_DATA=1 with bit_cnt stuck at 24.
- Load, then 5 clocks, then LOAD low with a coincident JOY_CLK rise -> state LOAD, bit_cnt=0, sr reloaded; JOY_DATA = ~joystick1[0].
- Load, 3 clocks, then JOY_CLK held for TIMEOUT+10 cycles -> exactly one timeout pulse, active=0, JOY_DATA=1, bit_cnt=3.
- Assert RESET_N low mid-frame at bit 10 -> JOY_DATA=1 asynchronously. After release with LOAD=0, state is LOAD after 3 cycles.

Source files
------------

// File: rtl/joy_db15_pkg.sv
// Shared types and constants for the DB15 serial joystick link.
// Pad bit positions follow the adapter's shift-register wiring.
package joy_db15_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  localparam int FRAME_BITS_DEF = 24;
  localparam int PAD_BITS       = 12;

  localparam int BIT_R  = 0;
  localparam int BIT_L  = 1;
  localparam int BIT_D  = 2;
  localparam int BIT_U  = 3;
  localparam int BIT_B1 = 4;
  localparam int BIT_B2 = 5;
  localparam int BIT_B3 = 6;
  localparam int BIT_B4 = 7;
  localparam int BIT_B5 = 8;
  localparam int BIT_B6 = 9;
  localparam int BIT_B7 = 10;
  localparam int BIT_B8 = 11;

endpackage

// File: rtl/joy_db15_tx_if.sv
// Serial DB15 link wires: the host drives clock and load, the device answers on data.
interface joy_db15_tx_if;

  logic JOY_CLK;
  logic JOY_LOAD;
  logic JOY_DATA;

  modport master (
    output JOY_CLK,
    output JOY_LOAD,
    input  JOY_DATA
  );

  modport slave (
    input  JOY_CLK,
    input  JOY_LOAD,
    output JOY_DATA
  );

endinterface

// File: rtl/db15_sync_edge.sv
// N-stage synchronizer with rise/fall detection; flops reset high because
// the link lines idle high.
module db15_sync_edge #(
  parameter int N = 2
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [N-1:0] sync_q;
  logic         prev_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= N'({sync_q, d});
      prev_q <= sync_q[N-1];
    end
  end

  assign q    = sync_q[N-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// Device side of the DB15 serial joystick link: captures both pads while LOAD
// is low, then shifts one bit per host clock rise onto an active-low data line.
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic                               clk_sys,
  input  logic                               RESET_N,
  joy_db15_tx_if.slave                       link,
  input  logic [PAD_BITS-1:0]                joystick1,
  input  logic [PAD_BITS-1:0]                joystick2,
  output logic [$clog2(FRAME_BITS+1)-1:0]    bit_cnt,
  output logic                               frame_done,
  output logic                               timeout,
  output logic                               active
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam int WD_W  = $clog2(TIMEOUT);

  state_t                  state, state_n;
  logic [FRAME_BITS-1:0]   sr, sr_n;
  logic [FRAME_BITS-1:0]   frame_word;
  logic [CNT_W-1:0]        bit_cnt_n;
  logic [WD_W-1:0]         wdog, wdog_n;
  logic                    frame_done_n;
  logic                    timeout_n;

  logic clk_sync, clk_rise, clk_fall;
  logic load_sync, load_rise, load_fall;
  logic unused_edges;

  db15_sync_edge #(.N(SYNC_STAGES)) u_sync_clk (
    .clk_sys (clk_sys),
    .rst_n   (RESET_N),
    .d       (link.JOY_CLK),
    .q       (clk_sync),
    .rise    (clk_rise),
    .fall    (clk_fall)
  );

  db15_sync_edge #(.N(SYNC_STAGES)) u_sync_load (
    .clk_sys (clk_sys),
    .rst_n   (RESET_N),
    .d       (link.JOY_LOAD),
    .q       (load_sync),
    .rise    (load_rise),
    .fall    (load_fall)
  );

  assign unused_edges = ^{clk_sync, clk_fall, load_rise, load_fall};

  // Player 2 sits in the upper half so player 1 bit 0 leaves the chain first.
  assign frame_word = FRAME_BITS'({joystick2, joystick1});

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      sr            <= '0;
      bit_cnt       <= '0;
      wdog          <= '0;
      frame_done    <= 1'b0;
      timeout       <= 1'b0;
      link.JOY_DATA <= 1'b1;
    end else begin
      state         <= state_n;
      sr            <= sr_n;
      bit_cnt       <= bit_cnt_n;
      wdog          <= wdog_n;
      frame_done    <= frame_done_n;
      timeout       <= timeout_n;
      link.JOY_DATA <= ~sr[0];
    end
  end

  // A new load always beats a shift edge; an idle host clock eventually
  // releases the line so a stalled host never sees stale buttons.
  always_comb begin
    state_n      = state;
    sr_n         = sr;
    bit_cnt_n    = bit_cnt;
    wdog_n       = wdog;
    frame_done_n = 1'b0;
    timeout_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!load_sync) state_n = LOAD;
      end
      LOAD: begin
        if (!load_sync) begin
          sr_n      = frame_word;
          bit_cnt_n = '0;
        end else begin
          state_n = SHIFT;
          wdog_n  = '0;
        end
      end
      SHIFT: begin
        if (!load_sync) begin
          state_n = LOAD;
        end else if (clk_rise) begin
          sr_n   = {1'b0, sr[FRAME_BITS-1:1]};
          wdog_n = '0;
          if (bit_cnt != CNT_W'(FRAME_BITS)) begin
            bit_cnt_n    = bit_cnt + 1'b1;
            frame_done_n = (bit_cnt == CNT_W'(FRAME_BITS - 1));
          end
        end else if (wdog == WD_W'(TIMEOUT - 1)) begin
          timeout_n = 1'b1;
          state_n   = IDLE;
          sr_n      = '0;
        end else begin
          wdog_n = wdog + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign active = (state == SHIFT);

endmodule

// File: tb/tb_joy_db15_tx.sv
// Drives the host side of the DB15 link and compares the serial stream with a
// frame-level model: after n clock edges the line shows ~F[n], released past the end.
module tb_joy_db15_tx;

  localparam int FRAME_BITS  = 24;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 4096;

  logic        clk_sys = 1'b0;
  logic        RESET_N;
  logic [11:0] joystick1;
  logic [11:0] joystick2;
  logic [4:0]  bit_cnt;
  logic        frame_done;
  logic        timeout;
  logic        active;

  joy_db15_tx_if link();

  joy_db15_tx #(
    .FRAME_BITS  (FRAME_BITS),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk_sys    (clk_sys),
    .RESET_N    (RESET_N),
    .link       (link),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .bit_cnt    (bit_cnt),
    .frame_done (frame_done),
    .timeout    (timeout),
    .active     (active)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;
  int timeout_pulses = 0;

  always @(negedge clk_sys) begin
    if (frame_done === 1'b1) done_pulses++;
    if (timeout === 1'b1) timeout_pulses++;
  end

  logic [23:0] model_frame = '0;
  int          model_edges = 0;

  function automatic logic [31:0] exp_data();
    if (model_edges >= FRAME_BITS) return 32'd1;
    return {31'd0, ~model_frame[model_edges]};
  endfunction

  function automatic logic [31:0] exp_cnt();
    return (model_edges >= FRAME_BITS) ? 32'(FRAME_BITS) : 32'(model_edges);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus(input logic joy_clk, input logic joy_load, input int hold);
    link.JOY_CLK  = joy_clk;
    link.JOY_LOAD = joy_load;
    cycles(hold);
  endtask

  task automatic check_model(input string tag);
    checkOutput({tag, " data"}, 32'(link.JOY_DATA), exp_data());
    checkOutput({tag, " cnt"}, 32'(bit_cnt), exp_cnt());
  endtask

  task automatic load_frame(input logic [11:0] j1, input logic [11:0] j2);
    joystick1 = j1;
    joystick2 = j2;
    applyStimulus(1'b0, 1'b0, 8);
    applyStimulus(1'b0, 1'b1, 6);
    model_frame = {j2, j1};
    model_edges = 0;
  endtask

  task automatic shift_bit();
    applyStimulus(1'b1, 1'b1, 5);
    model_edges++;
    applyStimulus(1'b0, 1'b1, 5);
  endtask

  initial begin
    int base;
    int n;

    RESET_N   = 1'b0;
    joystick1 = '0;
    joystick2 = '0;
    link.JOY_CLK  = 1'b0;
    link.JOY_LOAD = 1'b1;
    cycles(3);
    checkOutput("rst data", 32'(link.JOY_DATA), 32'd1);
    checkOutput("rst cnt", 32'(bit_cnt), 32'd0);
    checkOutput("rst active", 32'(active), 32'd0);
    checkOutput("rst done", 32'(frame_done), 32'd0);
    checkOutput("rst timeout", 32'(timeout), 32'd0);
    RESET_N = 1'b1;
    cycles(5);
    checkOutput("idle data", 32'(link.JOY_DATA), 32'd1);
    checkOutput("idle active", 32'(active), 32'd0);
    checkOutput("idle pulses", 32'(done_pulses + timeout_pulses), 32'd0);

    // Directed frame: R and U pressed on player 1.
    load_frame(12'h009, 12'h000);
    checkOutput("f1 active", 32'(active), 32'd1);
    check_model("f1 pre");
    base = done_pulses;
    for (int i = 0; i < FRAME_BITS; i++) begin
      shift_bit();
      check_model("f1 bit");
      if (i == FRAME_BITS - 2) checkOutput("f1 early done", 32'(done_pulses - base), 32'd0);
    end
    checkOutput("f1 done once", 32'(done_pulses - base), 32'd1);
    checkOutput("f1 cnt 24", 32'(bit_cnt), 32'd24);

    // Player 2 all pressed, then run past the frame end.
    load_frame(12'h000, 12'hFFF);
    check_model("f2 pre");
    base = done_pulses;
    for (int i = 0; i < FRAME_BITS + 2; i++) begin
      shift_bit();
      check_model("f2 bit");
    end
    checkOutput("f2 done once", 32'(done_pulses - base), 32'd1);
    checkOutput("f2 tail data", 32'(link.JOY_DATA), 32'd1);
    checkOutput("f2 cnt sat", 32'(bit_cnt), 32'd24);

    // Random frames with pad inputs wiggling during the shift.
    for (int f = 0; f < 5; f++) begin
      load_frame(12'($urandom), 12'($urandom));
      check_model("rnd pre");
      base = done_pulses;
      n = int'($urandom_range(0, 27));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          joystick1 = 12'($urandom);
          joystick2 = 12'($urandom);
        end
        shift_bit();
        check_model("rnd bit");
      end
      checkOutput("rnd done", 32'(done_pulses - base), (n >= FRAME_BITS) ? 32'd1 : 32'd0);
    end

    // Load arriving together with a clock rise mid-frame.
    load_frame(12'($urandom), 12'($urandom));
    for (int i = 0; i < 5; i++) shift_bit();
    joystick1 = 12'($urandom);
    joystick2 = 12'($urandom);
    base = done_pulses;
    applyStimulus(1'b1, 1'b0, 8);
    checkOutput("race active", 32'(active), 32'd0);
    checkOutput("race cnt", 32'(bit_cnt), 32'd0);
    checkOutput("race data", 32'(link.JOY_DATA), {31'd0, ~joystick1[0]});
    checkOutput("race done", 32'(done_pulses - base), 32'd0);
    applyStimulus(1'b1, 1'b1, 6);
    applyStimulus(1'b0, 1'b1, 5);
    model_frame = {joystick2, joystick1};
    model_edges = 0;
    checkOutput("race shift", 32'(active), 32'd1);
    check_model("race pre");
    for (int i = 0; i < 4; i++) begin
      shift_bit();
      check_model("race bit");
    end

    // Host stalls with the clock low: one watchdog abandon.
    load_frame(12'($urandom) | 12'h010, 12'($urandom));
    for (int i = 0; i < 3; i++) shift_bit();
    checkOutput("wd active", 32'(active), 32'd1);
    base = timeout_pulses;
    cycles(TIMEOUT + 10);
    checkOutput("wd pulse once", 32'(timeout_pulses - base), 32'd1);
    checkOutput("wd active", 32'(active), 32'd0);
    checkOutput("wd data", 32'(link.JOY_DATA), 32'd1);
    checkOutput("wd cnt", 32'(bit_cnt), 32'd3);

    // Reset asserted mid-frame with LOAD already low at release.
    load_frame(12'($urandom) | 12'h001, 12'($urandom));
    for (int i = 0; i < 10; i++) shift_bit();
    link.JOY_LOAD = 1'b0;
    RESET_N = 1'b0;
    #2;
    checkOutput("mid rst data", 32'(link.JOY_DATA), 32'd1);
    checkOutput("mid rst cnt", 32'(bit_cnt), 32'd0);
    checkOutput("mid rst active", 32'(active), 32'd0);
    cycles(1);
    RESET_N = 1'b1;
    cycles(2);
    checkOutput("rel early data", 32'(link.JOY_DATA), 32'd1);
    cycles(6);
    checkOutput("rel load data", 32'(link.JOY_DATA), {31'd0, ~joystick1[0]});
    checkOutput("rel load active", 32'(active), 32'd0);
    applyStimulus(1'b0, 1'b1, 6);
    model_frame = {joystick2, joystick1};
    model_edges = 0;
    checkOutput("rel shift", 32'(active), 32'd1);
    base = done_pulses;
    for (int i = 0; i < FRAME_BITS; i++) begin
      shift_bit();
      check_model("rel bit");
    end
    checkOutput("rel done", 32'(done_pulses - base), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
